// File: rtl/i2c_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_byte_fifo                                              |
// | Description : Synchronous first-word-fall-through byte FIFO used as the  |
// |               I2C TX and RX buffer. Also builds the 8-bit status byte    |
// |               read back through the APB status register.                 |
// | Options     : I2C_FIFO_FLUSH_EN adds flush_i and the flush_busy status.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module i2c_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [7:0]            status_o,
`ifdef I2C_FIFO_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  clr_err_i
);

  localparam int                C_DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] C_AFULL  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = AEMPTY_LVL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_afull;
  logic w_aempty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_udf_evt;
  logic w_flush;
  logic w_flush_busy;

`ifdef I2C_FIFO_FLUSH_EN
  logic r_flush_busy;

  assign w_flush      = flush_i;
  assign w_flush_busy = r_flush_busy;

  // flush_busy is a one-cycle echo of the flush edge
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_flush_busy <= 1'b0;
    end else begin
      r_flush_busy <= flush_i;
    end
  end
`else
  assign w_flush      = 1'b0;
  assign w_flush_busy = 1'b0;
`endif

  // Full when pointers match except for the wrap bit, empty when identical
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_afull  = (r_count >= C_AFULL);
  assign w_aempty = (r_count <= C_AEMPTY);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; the write lands exactly in the slot being vacated.
  assign w_pop_ok  = rd_en_i && !w_empty;
  assign w_push_ok = wr_en_i && (!w_full || rd_en_i);
  assign w_ovf_evt = wr_en_i && w_full && !rd_en_i;
  assign w_udf_evt = rd_en_i && w_empty;

  assign data_o   = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign count_o  = r_count;
  assign full_o   = w_full;
  assign empty_o  = w_empty;
  assign status_o = {1'b0, w_flush_busy, r_udf, r_ovf, w_afull, w_aempty, w_full, w_empty};

  // Storage write; array contents are deliberately left unreset
  always_ff @(posedge pclk_i) begin
    if (!preset_i && !w_flush && w_push_ok) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  // Pointer, occupancy and sticky error bookkeeping
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (w_flush) begin
      // Flush discards contents but keeps the sticky error history
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + C_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      // A fresh error in the clear cycle wins over the clear
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_err_i) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
      end else if (clr_err_i) begin
        r_udf <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_i2c_byte_fifo                                           |
// | Description : Self-checking bench for i2c_byte_fifo with a queue-based   |
// |               reference model and a decoupled scoreboard monitor.        |
// | Options     : I2C_FIFO_FLUSH_EN exercises the flush port.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_i2c_byte_fifo;

  typedef struct {
    logic [7:0] data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic [7:0] status;
  } exp_t;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic [7:0] status;
`ifdef I2C_FIFO_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_ovf = 0;
  bit         m_udf = 0;
  bit         m_fb = 0;

  i2c_byte_fifo dut (
    .pclk_i    (clk),
    .preset_i  (preset),
    .wr_en_i   (wr_en),
    .data_i    (din),
    .rd_en_i   (rd_en),
    .data_o    (dout),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .status_o  (status),
`ifdef I2C_FIFO_FLUSH_EN
    .flush_i   (flush),
`endif
    .clr_err_i (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_o", dout, e.data);
        chk("count_o", {3'b000, count}, {3'b000, e.count});
        chk("empty_o", {7'd0, empty}, {7'd0, e.empty});
        chk("full_o", {7'd0, full}, {7'd0, full_exp(e)});
        chk("status_o", status, e.status);
      end
    end
  end

  function automatic logic full_exp(input exp_t e);
    return e.full;
  endfunction

  // Drive one cycle of stimulus and record the model's view after the edge
  task automatic step(input bit wr, input bit [7:0] d, input bit rd,
                      input bit clr, input bit rst, input bit fl);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    int   n;
    @(negedge clk);
`ifndef I2C_FIFO_FLUSH_EN
    fl = 1'b0;
`endif
    wr_en   = wr;
    din     = d;
    rd_en   = rd;
    clr_err = clr;
    preset  = rst;
`ifdef I2C_FIFO_FLUSH_EN
    flush   = fl;
`endif
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      m_fb  = 0;
    end else if (fl) begin
      mq.delete();
      m_fb = 1;
    end else begin
      m_fb      = 0;
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) void'(mq.pop_front());
      if (wr && (!was_full || rd)) mq.push_back(d);
      if (wr && was_full && !rd) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (rd && was_empty) m_udf = 1;
      else if (clr) m_udf = 0;
    end
    n        = mq.size();
    e.data   = (n > 0) ? mq[0] : 8'h00;
    e.count  = 5'(n);
    e.empty  = (n == 0);
    e.full   = (n == 16);
    e.status = {1'b0, m_fb, m_udf, m_ovf, (n >= 12), (n <= 2), (n == 16), (n == 0)};
    exp_q.push_back(e);
  endtask

  task automatic push(input bit [7:0] d);
    step(1, d, 0, 0, 0, 0);
  endtask

  task automatic pop();
    step(0, 8'h00, 1, 0, 0, 0);
  endtask

  // Stimulus: directed scenarios followed by phased random traffic
  initial begin
    int pw;
    int pr;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    push(8'hA5);
    pop();

    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    for (int i = 0; i < 16; i++) pop();
    step(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    step(1, 8'h55, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) pop();

    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 40; i++) step(1, 8'(8'h40 + i), 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) pop();

    step(1, 8'h3C, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    pop();
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

`ifdef I2C_FIFO_FLUSH_EN
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    step(1, 8'hEE, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    for (int ph = 0; ph < 12; ph++) begin
      pw = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 50);
      pr = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 85 : 50);
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 99) < pw, 8'($urandom),
             $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5,
             $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 2);
      end
    end
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_byte_fifo.md
Name: i2c_byte_fifo

Overview:
- Synchronous byte FIFO that sits directly downstream of the APB register block. It is instantiated twice, as TX-FIFO and as RX-FIFO.
- TX-FIFO: the one-cycle transmit-write strobe pushes the transmit register byte; the I2C core pops bytes for shifting.
- RX-FIFO: the I2C core pushes received bytes; the one-cycle RX-read strobe pops them.
- Produces the 8-bit status byte consumed by the APB block's status register read (address 2).

Parameters:
- DATA_WIDTH, 8, width of each stored entry.
- ADDR_WIDTH, 4, log2 of depth (depth = 2**ADDR_WIDTH = 16).
- AFULL_LVL, 12, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- pclk_i  in  1  clock; all state updates on rising edge.
- preset_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  push request, one cycle = one entry.
- data_i  in  DATA_WIDTH  push data.
- rd_en_i  in  1  pop request, one cycle = one entry.
- data_o  out  DATA_WIDTH  head entry (first-word-fall-through).
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- full_o  out  1  count == depth.
- empty_o  out  1  count == 0.
- status_o  out  8  packed status byte (layout below).
- clr_err_i  in  1  clears sticky overflow/underflow bits.

Behaviour:
- Reset (preset_i high at clock edge; priority over all other inputs):
  - wr_ptr, rd_ptr, count = 0; overflow and underflow flags = 0.
  - After reset: data_o = 0, empty_o = 1, full_o = 0, status_o = 8'h05.
  - Storage array contents are not reset.
- Pointers:
  - ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits index the array.
  - Natural wrap: 2**ADDR_WIDTH-1 -> 0, with the MSB toggling.
  - full when the pointers differ only in the MSB; empty when equal.
- Push accepted = wr_en_i && !full_o:
  - mem[wr_ptr] <= data_i; wr_ptr + 1.
- Push while full (and no pop that cycle):
  - Data dropped, pointers unchanged, overflow set (sticky).
- Pop accepted = rd_en_i && !empty_o:
  - rd_ptr + 1.
- Pop while empty:
  - No pointer change, underflow set (sticky).
- Simultaneous push and pop:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: pop accepted, and the push is also accepted into the freed slot. count stays at depth, no overflow.
  - Empty: push accepted, pop rejected, underflow set. count becomes 1.
- count_o updates +1 / -1 / 0 on the same edge as the pointers.
- data_o:
  - Combinational read of mem[rd_ptr] while empty_o=0; forced to 0 while empty_o=1.
  - A byte pushed into an empty FIFO appears on data_o the cycle after the push edge (1-cycle latency).
- All flags are decoded from registered pointers/count, so they are valid the cycle after the causing edge.
- Sticky error bits:
  - clr_err_i clears them on the next edge.
  - If a new error occurs in the same cycle as clr_err_i, the new error wins and the bit stays set.
- status_o layout:
  - [0] empty
  - [1] full
  - [2] almost_empty
  - [3] almost_full
  - [4] overflow (sticky)
  - [5] underflow (sticky)
  - [6] flush_busy (see optional feature, else 0)
  - [7] 0
- Widths: count arithmetic is ADDR_WIDTH+1 bits, never saturating (overflow is impossible by construction). Threshold compares are unsigned.

Optional Feature:
- Macro: I2C_FIFO_FLUSH_EN.
- When defined:
  - Adds input flush_i (1 bit).
  - flush_i high at an edge sets wr_ptr = rd_ptr = 0 and count = 0; sticky bits are preserved.
  - Any wr_en_i/rd_en_i in that cycle is ignored and flags no error.
  - status_o[6] is high for exactly the cycle following a flush edge.
  - Priority: preset_i > flush_i > push/pop.
- When not defined: no flush_i port, and status_o[6] is tied 0.

Test Plan:
- Reset then idle: hold preset_i 2 cycles, release -> count_o=0, empty_o=1, full_o=0, data_o=8'h00, status_o=8'h05.
- Push 8'hA5 with FIFO empty -> next cycle data_o=8'hA5, count_o=1, empty_o=0. Pop -> next cycle empty_o=1, data_o=8'h00.
- Push 16 bytes 8'h00..8'h0F -> full_o=1, status_o=8'h0A. 17th push 8'hFF -> count_o stays 16, status_o[4]=1. Pop 16 -> data sequence 00..0F in order (0xFF is absent).
- Full FIFO, simultaneous push 8'h55 + pop -> count_o stays 16, no overflow; after draining, the last byte read is 8'h55. Pointer wrap verified by 40 push/pop cycles with ordered data.
- Empty FIFO, simultaneous push 8'h3C + pop -> count_o=1, data_o=8'h3C, status_o[5]=1. clr_err_i one cycle -> status_o[5]=0. clr_err_i together with a pop on an empty FIFO -> bit remains 1.
- With I2C_FIFO_FLUSH_EN: fill 5 bytes, assert flush_i with a simultaneous wr_en_i -> next cycle count_o=0, empty_o=1, status_o[6]=1 for one cycle, no error bits set.
